accum_frame_sequencer: RTL and testbench

//   Initiator side of the accumulator start/stop protocol. Buffers an incoming

---
 rtl/accum_frame_sequencer_if.sv | 13 +
 rtl/accum_frame_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_accum_frame_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_frame_sequencer_if.sv
// Valid/ready sample stream used on the producer side of accum_frame_sequencer.
//   master : drives data/valid, samples ready (sample producer, e.g. FFT/conv stage)
//   slave  : samples data/valid, drives ready (the sequencer's input buffer)
interface accum_frame_sequencer_if #(
  parameter int unsigned DataWidth = 64
);
  logic [DataWidth-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/accum_frame_sequencer.sv
// Initiator side of the accumulator start/stop protocol. Buffers a valid/ready stream of
// complex_t samples ({r,i}, IEEE-754 single each) and replays it to an accumulator as
// gapless frames of FRAME_LEN samples: acc_start with sample 0, samples 1..FRAME_LEN-1 on
// consecutive cycles, then acc_stop with acc_in=0. It then waits for a rising edge of the
// accumulator's output_valid (acc_valid) before the next frame may begin.
//
// Ports
//   clk          clock, all logic on the rising edge
//   reset        asynchronous active-high reset
//   s            sample stream in (slave modport: data/valid in, ready out)
//   acc_in       sample to accumulator (0 outside START/STREAM)
//   acc_start    one-cycle pulse, coincides with sample 0
//   acc_stop     one-cycle pulse after the last sample
//   acc_valid    accumulator output_valid
//   frame_done   one-cycle pulse once the accumulator result has been seen
//   busy         sequencer not idle
//   frame_count  completed frames, wraps at 16 bits
//   timeout_err  sticky watchdog flag
//
// Optional feature: define ACCUM_SEQ_TIMEOUT_EN to bound the wait for acc_valid to
// TIMEOUT_CYCLES cycles; otherwise the wait is unbounded and timeout_err is tied low.
module accum_frame_sequencer #(
  parameter int unsigned FRAME_LEN      = 64,
  parameter int unsigned FIFO_DEPTH     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  accum_frame_sequencer_if.slave        s,
  output logic [63:0]                   acc_in,
  output logic                          acc_start,
  output logic                          acc_stop,
  input  logic                          acc_valid,
  output logic                          frame_done,
  output logic                          busy,
  output logic [15:0]                   frame_count,
  output logic                          timeout_err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  if (FRAME_LEN < 1 || FRAME_LEN > FIFO_DEPTH || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("accum_frame_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {StIdle, StStart, StStream, StStop, StWait} state_e;

  // Sample buffer
  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [63:0]   rd_data;
  logic          push, pop;

  // Sequencer state and registered outputs
  state_e        state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [63:0]   acc_in_q, acc_in_d;
  logic          acc_start_q, acc_start_d;
  logic          acc_stop_q, acc_stop_d;
  logic          frame_done_q, frame_done_d;
  logic          busy_q, busy_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          acc_valid_q;
  logic          acc_valid_rise;

`ifdef ACCUM_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  assign s.ready        = (fifo_cnt_q < CW'(FIFO_DEPTH));
  assign push           = s.valid && s.ready;
  assign rd_data        = mem_q[rd_ptr_q];
  // Previous acc_valid is tracked in every state so a level already high at WAIT entry
  // is not mistaken for a fresh result.
  assign acc_valid_rise = acc_valid && !acc_valid_q;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    acc_in_d      = '0;
    acc_start_d   = 1'b0;
    acc_stop_d    = 1'b0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    pop           = 1'b0;
`ifdef ACCUM_SEQ_TIMEOUT_EN
    tmo_d         = tmo_q;
    err_d         = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Only a complete frame is ever started, so every later pop finds data.
        if (fifo_cnt_q >= CW'(FRAME_LEN)) begin
          state_d     = StStart;
          acc_start_d = 1'b1;
          acc_in_d    = rd_data;
          pop         = 1'b1;
        end
      end
      StStart: begin
        if (FRAME_LEN == 1) begin
          state_d    = StStop;
          acc_stop_d = 1'b1;
        end else begin
          state_d  = StStream;
          acc_in_d = rd_data;
          pop      = 1'b1;
          beat_d   = CW'(1);
        end
      end
      StStream: begin
        // beat_q is the index of the sample currently on acc_in.
        if (beat_q == CW'(FRAME_LEN - 1)) begin
          state_d    = StStop;
          acc_stop_d = 1'b1;
        end else begin
          acc_in_d = rd_data;
          pop      = 1'b1;
          beat_d   = beat_q + CW'(1);
        end
      end
      StStop: begin
        state_d = StWait;
`ifdef ACCUM_SEQ_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      StWait: begin
        if (acc_valid_rise) begin
          state_d       = StIdle;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
`ifdef ACCUM_SEQ_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
  end

  // Storage only; occupancy and pointers carry the reset state.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s.data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      beat_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      acc_in_q      <= '0;
      acc_start_q   <= 1'b0;
      acc_stop_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      acc_valid_q   <= 1'b0;
`ifdef ACCUM_SEQ_TIMEOUT_EN
      tmo_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      acc_in_q      <= acc_in_d;
      acc_start_q   <= acc_start_d;
      acc_stop_q    <= acc_stop_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      acc_valid_q   <= acc_valid;
`ifdef ACCUM_SEQ_TIMEOUT_EN
      tmo_q         <= tmo_d;
      err_q         <= err_d;
`endif
    end
  end

  assign acc_in      = acc_in_q;
  assign acc_start   = acc_start_q;
  assign acc_stop    = acc_stop_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;
`ifdef ACCUM_SEQ_TIMEOUT_EN
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_accum_frame_sequencer.sv
// Bench for accum_frame_sequencer. Reference model: a queue of samples the buffer should
// hold; a monitor collects each observed frame, and every frame is compared against the
// next FRAME_LEN samples of the queue. A second instance covers FRAME_LEN=1.
module tb_accum_frame_sequencer;
  localparam int unsigned FL    = 64;
  localparam int unsigned DEPTH = 128;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance
  accum_frame_sequencer_if #(.DataWidth(64)) s_if ();
  logic [63:0] acc_in;
  logic        acc_start, acc_stop, acc_valid, frame_done, busy, timeout_err;
  logic [15:0] frame_count;

  accum_frame_sequencer #(.FRAME_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(256)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .s          (s_if),
    .acc_in     (acc_in),
    .acc_start  (acc_start),
    .acc_stop   (acc_stop),
    .acc_valid  (acc_valid),
    .frame_done (frame_done),
    .busy       (busy),
    .frame_count(frame_count),
    .timeout_err(timeout_err)
  );

  // Single-sample-frame instance
  accum_frame_sequencer_if #(.DataWidth(64)) s1_if ();
  logic [63:0] acc_in1;
  logic        acc_start1, acc_stop1, frame_done1, busy1, timeout_err1;
  logic [15:0] frame_count1;

  accum_frame_sequencer #(.FRAME_LEN(1), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(256)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .s          (s1_if),
    .acc_in     (acc_in1),
    .acc_start  (acc_start1),
    .acc_stop   (acc_stop1),
    .acc_valid  (1'b0),
    .frame_done (frame_done1),
    .busy       (busy1),
    .frame_count(frame_count1),
    .timeout_err(timeout_err1)
  );

  int errors = 0;
  int checks = 0;

  logic [63:0] model_q[$];

  // Frame monitor
  logic [63:0] got_samples[$];
  logic [63:0] cur[$];
  int unsigned got_len[$], got_start[$], got_stop[$];
  int unsigned cur_start;
  bit          in_frame = 1'b0;
  int          stray = 0;

  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
      cur.delete();
    end else if (acc_start) begin
      in_frame  = 1'b1;
      cur.delete();
      cur.push_back(acc_in);
      cur_start = cyc;
    end else if (acc_stop) begin
      if (acc_in != 64'd0) stray++;
      if (in_frame) begin
        foreach (cur[k]) got_samples.push_back(cur[k]);
        got_len.push_back(cur.size());
        got_start.push_back(cur_start);
        got_stop.push_back(cyc);
      end
      in_frame = 1'b0;
    end else if (in_frame) begin
      cur.push_back(acc_in);
    end else if (acc_in != 64'd0) begin
      stray++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one beat; acceptance expected only while the modelled buffer has room.
  task automatic push(input logic [63:0] d);
    s_if.data  = d;
    s_if.valid = 1'b1;
    chk("s_ready", s_if.ready, model_q.size() < DEPTH);
    if (model_q.size() < DEPTH) model_q.push_back(d);
    @(posedge clk); #1;
    s_if.valid = 1'b0;
  endtask

  task automatic push_random(input int n, input int max_gap);
    for (int k = 0; k < n; k++) begin
      push({$urandom, $urandom});
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_frames(input int n);
    int budget = 400;
    while (got_len.size() < n && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("frame_arrival", got_len.size() >= n, 1'b1);
  endtask

  task automatic check_frame(input int idx, input string tag);
    logic [63:0] e, g;
    if (got_len.size() <= idx) return;
    chk({tag, "_len"}, got_len[idx], FL);
    chk({tag, "_start_to_stop"}, got_stop[idx] - got_start[idx], FL);
    for (int k = 0; k < int'(got_len[idx]); k++) begin
      e = (model_q.size() > 0) ? model_q.pop_front() : 64'hdead_beef_dead_beef;
      g = (got_samples.size() > 0) ? got_samples.pop_front() : 64'hbad0_bad0_bad0_bad0;
      if (k < int'(FL)) chk({tag, "_data"}, g, e);
    end
  endtask

  // Rising edge of acc_valid while waiting; expects completion the next cycle.
  task automatic ack(input logic [15:0] exp_cnt);
    acc_valid = 1'b1;
    @(posedge clk); #1;
    acc_valid = 1'b0;
    @(negedge clk);
    chk("frame_done", frame_done, 1'b1);
    chk("frame_count", frame_count, exp_cnt);
    chk("busy_after_done", busy, 1'b0);
    @(negedge clk);
    chk("frame_done_one_cycle", frame_done, 1'b0);
  endtask

  initial begin
    int unsigned last_cyc, t;
    int budget;
    logic [63:0] d1;

    s_if.data  = '0;
    s_if.valid = 1'b0;
    s1_if.data  = '0;
    s1_if.valid = 1'b0;
    acc_valid  = 1'b0;

    // Reset state
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_acc_in", acc_in, 64'd0);
    chk("rst_acc_start", acc_start, 1'b0);
    chk("rst_acc_stop", acc_stop, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_count", frame_count, 16'd0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_s_ready", s_if.ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full frame of ramp samples; start one cycle after the 64th sample lands
    for (int k = 0; k < int'(FL); k++) begin
      logic [31:0] r;
      r = 32'h4348_0000 + 32'(k) * 32'h0001_0000;
      push({r, r});
    end
    last_cyc = cyc;
    wait_frames(1);
    if (got_start.size() > 0) chk("start_latency", got_start[0], last_cyc + 1);
    check_frame(0, "f0");
    chk("busy_in_wait", busy, 1'b1);
    chk("no_done_in_wait", frame_done, 1'b0);
    t = (got_stop.size() > 0) ? got_stop[0] : cyc;
    budget = 100;
    while (cyc < t + 10 && budget > 0) begin @(posedge clk); #1; budget--; end
    ack(16'd1);

    // 63 samples never start a frame; the 64th does
    push_random(FL - 1, 2);
    repeat (100) begin @(posedge clk); #1; end
    chk("partial_no_start", got_len.size(), 1);
    chk("partial_idle", busy, 1'b0);
    push({$urandom, $urandom});
    wait_frames(2);
    check_frame(1, "f1");

    // Fill while waiting: 128 accepted, the rest refused, order kept
    push_random(DEPTH, 0);
    chk("full_s_ready", s_if.ready, 1'b0);
    push_random(6, 0);
    chk("full_still_blocked", s_if.ready, 1'b0);
    chk("full_no_start", got_len.size(), 2);
    ack(16'd2);
    wait_frames(3);
    check_frame(2, "f2");
    ack(16'd3);

    // acc_valid already high at WAIT entry is stale
    repeat (10) begin @(posedge clk); #1; end
    acc_valid = 1'b1;
    wait_frames(4);
    check_frame(3, "f3");
    repeat (20) begin @(posedge clk); #1; end
    chk("stale_count", frame_count, 16'd3);
    chk("stale_busy", busy, 1'b1);
    acc_valid = 1'b0;
    @(posedge clk); #1;
    ack(16'd4);
    repeat (5) begin @(posedge clk); #1; end
    chk("empty_no_frame", got_len.size(), 4);

    // Reset in the middle of a streaming frame
    push_random(FL, 0);
    budget = 200;
    while (!(in_frame && cur.size() >= 30) && budget > 0) begin @(posedge clk); #1; budget--; end
    chk("reached_beat30", budget > 0, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_acc_in", acc_in, 64'd0);
    chk("mid_rst_acc_start", acc_start, 1'b0);
    chk("mid_rst_acc_stop", acc_stop, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_frame_count", frame_count, 16'd0);
    chk("mid_rst_s_ready", s_if.ready, 1'b1);
    model_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    push_random(FL, 1);
    wait_frames(5);
    check_frame(4, "f4");
    ack(16'd1);

    // FRAME_LEN=1: start and stop on consecutive cycles
    d1 = {$urandom, $urandom};
    chk("fl1_ready", s1_if.ready, 1'b1);
    s1_if.data  = d1;
    s1_if.valid = 1'b1;
    @(posedge clk); #1;
    s1_if.valid = 1'b0;
    @(negedge clk);
    chk("fl1_no_start_yet", acc_start1, 1'b0);
    @(negedge clk);
    chk("fl1_start", acc_start1, 1'b1);
    chk("fl1_data", acc_in1, d1);
    chk("fl1_no_stop", acc_stop1, 1'b0);
    @(negedge clk);
    chk("fl1_stop", acc_stop1, 1'b1);
    chk("fl1_start_gone", acc_start1, 1'b0);
    chk("fl1_stop_data", acc_in1, 64'd0);
    chk("fl1_busy", busy1, 1'b1);
    chk("fl1_count", frame_count1, 16'd0);
    chk("fl1_done", frame_done1, 1'b0);
    chk("fl1_tmo", timeout_err1, 1'b0);

    // No result from the accumulator
    push_random(FL, 0);
    wait_frames(6);
    check_frame(5, "f5");
    t = (got_stop.size() > 5) ? got_stop[5] : cyc;
`ifdef ACCUM_SEQ_TIMEOUT_EN
    budget = 400;
    while (cyc < t + 256 && budget > 0) begin @(posedge clk); #1; budget--; end
    @(negedge clk);
    chk("tmo_not_yet", timeout_err, 1'b0);
    @(negedge clk);
    chk("tmo_set", timeout_err, 1'b1);
    chk("tmo_idle", busy, 1'b0);
    chk("tmo_no_done", frame_done, 1'b0);
    chk("tmo_count", frame_count, 16'd1);
    repeat (5) @(negedge clk);
    chk("tmo_sticky", timeout_err, 1'b1);
`else
    repeat (300) begin @(posedge clk); #1; end
    chk("no_tmo_err", timeout_err, 1'b0);
    chk("no_tmo_busy", busy, 1'b1);
    chk("no_tmo_count", frame_count, 16'd1);
`endif

    chk("acc_in_zero_outside_frames", stray, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
